// File: rtl/lcd1602_bus_arbiter.sv
// LCD1602 bus owner: waits out power-on, plays the fixed init sequence, then
// serves two byte-write clients round-robin with E-strobe timing and busy waits.
module lcd1602_bus_arbiter #(
  parameter int unsigned SETUP_CYC     = 4,
  parameter int unsigned EN_CYC        = 12,
  parameter int unsigned HOLD_CYC      = 4,
  parameter int unsigned WAIT_CYC      = 2000,
  parameter int unsigned LONG_WAIT_CYC = 82000,
  parameter int unsigned PWRON_CYC     = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       rs0,
  input  logic [7:0] dat0,
  output logic       ack0,
  input  logic       req1,
  input  logic       rs1,
  input  logic [7:0] dat1,
  output logic       ack1,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_dat,
  output logic       ready
);
  localparam logic [23:0] PWRON_LAST = 24'(PWRON_CYC - 1);
  localparam logic [23:0] SETUP_LAST = 24'(SETUP_CYC - 1);
  localparam logic [23:0] EN_LAST    = 24'(EN_CYC - 1);
  localparam logic [23:0] HOLD_LAST  = 24'(HOLD_CYC - 1);
  localparam logic [23:0] WAIT_LAST  = 24'(WAIT_CYC - 1);
  localparam logic [23:0] LONG_LAST  = 24'(LONG_WAIT_CYC - 1);

  typedef enum logic [2:0] {
    ST_PWRON, ST_INIT, ST_IDLE, ST_SETUP, ST_PULSE, ST_HOLD, ST_WAIT
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic        last_q, last_d;
  logic        ready_q, ready_d;
  logic        ack0_q, ack0_d, ack1_q, ack1_d;
  logic        lcd_rs_q, lcd_rs_d, lcd_en_q, lcd_en_d;
  logic [7:0]  lcd_dat_q, lcd_dat_d;
  logic [7:0]  init_byte;
  logic        long_wait, grant0, grant1;

  always_comb begin
    case (idx_q)
      2'd0:    init_byte = 8'h38;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h06;
      default: init_byte = 8'h01;
    endcase
  end

  // clear (0x01) and home (0x02/0x03) need the long busy wait
  assign long_wait = !lcd_rs_q && (lcd_dat_q[7:2] == 6'd0) && (lcd_dat_q[1:0] != 2'd0);
  assign grant0    = ready_q && req0 && (!req1 || last_q);
  assign grant1    = ready_q && req1 && (!req0 || !last_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 24'd1;
    idx_d     = idx_q;
    last_d    = last_q;
    ready_d   = ready_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    lcd_rs_d  = lcd_rs_q;
    lcd_en_d  = lcd_en_q;
    lcd_dat_d = lcd_dat_q;
    case (state_q)
      ST_PWRON: if (cnt_q == PWRON_LAST) begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
      ST_INIT: begin
        lcd_rs_d  = 1'b0;
        lcd_dat_d = init_byte;
        state_d   = ST_SETUP;
        cnt_d     = '0;
      end
      ST_IDLE: begin
        cnt_d    = '0;
        lcd_en_d = 1'b0;
        // pointer only moves when both clients contend
        if (req0 && req1) last_d = grant1;
        if (grant0) begin
          lcd_rs_d  = rs0;
          lcd_dat_d = dat0;
          ack0_d    = 1'b1;
          state_d   = ST_SETUP;
        end else if (grant1) begin
          lcd_rs_d  = rs1;
          lcd_dat_d = dat1;
          ack1_d    = 1'b1;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: if (cnt_q == SETUP_LAST) begin
        lcd_en_d = 1'b1;
        state_d  = ST_PULSE;
        cnt_d    = '0;
      end
      ST_PULSE: if (cnt_q == EN_LAST) begin
        lcd_en_d = 1'b0;
        state_d  = ST_HOLD;
        cnt_d    = '0;
      end
      ST_HOLD: if (cnt_q == HOLD_LAST) begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: if (cnt_q == (long_wait ? LONG_LAST : WAIT_LAST)) begin
        cnt_d = '0;
        if (ready_q) begin
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            ready_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_INIT;
          end
        end
      end
      default: begin
        state_d = ST_PWRON;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_PWRON;
      cnt_q     <= '0;
      idx_q     <= '0;
      last_q    <= 1'b1;
      ready_q   <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      lcd_rs_q  <= 1'b0;
      lcd_en_q  <= 1'b0;
      lcd_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      ready_q   <= ready_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      lcd_rs_q  <= lcd_rs_d;
      lcd_en_q  <= lcd_en_d;
      lcd_dat_q <= lcd_dat_d;
    end
  end

  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign lcd_rs  = lcd_rs_q;
  assign lcd_rw  = 1'b0;
  assign lcd_en  = lcd_en_q;
  assign lcd_dat = lcd_dat_q;
  assign ready   = ready_q;
endmodule
